// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Inputs are snapshotted once per frame; outputs are fully registered.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 1000,
    parameter int GUARD        = 8,
    parameter int BLINK_FRAMES = 62
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] digits,
    input  logic [7:0]  dp_en,
    input  logic [7:0]  blank,
    input  logic [7:0]  blink,
    output logic [7:0]  AN,
    output logic [7:0]  CN,
    output logic        frame_tick
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [FRM_W-1:0] frame_cnt;
    logic             phase;
    logic             first_load;
    logic [31:0]      snap_digits;
    logic [7:0]       snap_dp;
    logic [7:0]       snap_blank;
    logic [7:0]       snap_blink;

    logic       load;
    logic       dark;
    logic [3:0] cur_nib;
    logic [7:0] an_next;
    logic [7:0] cn_next;

    always_comb begin
        load    = (idx == 3'd0) && (div_cnt == '0);
        cur_nib = snap_digits[{idx, 2'b00} +: 4];
        dark    = (int'(div_cnt) < GUARD) || snap_blank[idx] || (snap_blink[idx] && !phase);
        an_next = 8'hFF;
        cn_next = 8'hFF;
        if (!dark) begin
            an_next = ~(8'b1 << idx);
            cn_next = {~snap_dp[idx], hex_to_seg(cur_nib)};
        end
    end

    // Scan counters, snapshot, blink phase and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt     <= '0;
            idx         <= 3'd0;
            frame_cnt   <= '0;
            phase       <= 1'b1;
            first_load  <= 1'b1;
            snap_digits <= 32'h0;
            snap_dp     <= 8'h0;
            snap_blank  <= 8'h0;
            snap_blink  <= 8'h0;
            AN          <= 8'hFF;
            CN          <= 8'hFF;
            frame_tick  <= 1'b0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                idx     <= idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            frame_tick <= load;
            AN         <= an_next;
            CN         <= cn_next;

            if (load) begin
                snap_digits <= digits;
                snap_dp     <= dp_en;
                snap_blank  <= blank;
                snap_blink  <= blink;
                // The frame right after reset starts the blink period rather than counting in it.
                if (first_load) begin
                    first_load <= 1'b0;
                end else if (frame_cnt == FRM_LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus queues cycle-stamped expectations,
// a monitor compares AN/CN/frame_tick every cycle against the queue head.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] digits;
    logic [7:0]  dp_en;
    logic [7:0]  blank;
    logic [7:0]  blink;
    logic [7:0]  AN;
    logic [7:0]  CN;
    logic        frame_tick;

    seg7_scan_driver #(
        .REFRESH_DIV (4),
        .GUARD       (1),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digits    (digits),
        .dp_en     (dp_en),
        .blank     (blank),
        .blink     (blink),
        .AN        (AN),
        .CN        (CN),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         stamp;
        logic [7:0] an;
        logic [7:0] cn;
        logic       ft;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Hand-computed cathode bytes per digit slot (digit i at bits [8i+:8]).
    localparam logic [63:0] CN_NORMAL = {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    localparam logic [63:0] CN_ALL_F  = {8{8'h8E}};
    localparam logic [63:0] CN_DP     = {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'h79, 8'h40};

    task automatic push(input int stamp, input logic [7:0] an, input logic [7:0] cn,
                        input logic ft, input string name);
        exp_t e;
        e.stamp = stamp;
        e.an    = an;
        e.cn    = cn;
        e.ft    = ft;
        e.name  = name;
        q.push_back(e);
    endtask

    task automatic push_frame(input int base, input int count, input logic [63:0] cns,
                              input logic [7:0] dark, input string name);
        for (int n = 0; n < count; n++) begin
            int slot;
            slot = n / 4;
            if ((n % 4) == 0 || dark[slot])
                push(base + n, 8'hFF, 8'hFF, (n == 0), name);
            else
                push(base + n, ~(8'b1 << slot), cns[slot*8 +: 8], 1'b0, name);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: outputs are stable between edges, checked 2 ns after each falling edge.
    always @(negedge clk) begin
        #2;
        while (q.size() > 0 && q[0].stamp <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            if (e.stamp < cyc || AN !== e.an || CN !== e.cn || frame_tick !== e.ft) begin
                n_fail++;
                $display("FAIL %s cyc=%0d (stamp %0d): got AN=%h CN=%h tick=%b, want AN=%h CN=%h tick=%b",
                         e.name, cyc, e.stamp, AN, CN, frame_tick, e.an, e.cn, e.ft);
            end
        end
    end

    initial begin
        reset  = 1'b0;
        digits = 32'h12345678;
        dp_en  = 8'h00;
        blank  = 8'h00;
        blink  = 8'h00;
        for (int c = 1; c <= 5; c++) push(c, 8'hFF, 8'hFF, 1'b0, "reset_hold");

        // Release: first snapshot on the next edge, frame_tick visible right after.
        wait_cyc(5);
        reset  = 1'b1;
        digits = 32'h76543210;
        push_frame(6, 32, CN_NORMAL, 8'h00, "scan_f0");
        push_frame(38, 32, CN_NORMAL, 8'h00, "scan_f1");

        // Change digits while digit 3 is being scanned.
        wait_cyc(51);
        digits = 32'hFFFFFFFF;
        push_frame(70, 32, CN_ALL_F, 8'h00, "snapshot_f2");

        wait_cyc(80);
        digits = 32'h76543210;
        blank  = 8'h02;
        dp_en  = 8'h03;
        push_frame(102, 32, CN_DP, 8'h02, "blank_dp_f3");

        // Blink period: phase visible in frames 4,5,8,9 and dark in frames 6,7.
        wait_cyc(110);
        blank = 8'h00;
        dp_en = 8'h00;
        blink = 8'h01;
        push_frame(134, 32, CN_NORMAL, 8'h00, "blink_on_f4");
        push_frame(166, 32, CN_NORMAL, 8'h00, "blink_on_f5");
        push_frame(198, 32, CN_NORMAL, 8'h01, "blink_off_f6");
        push_frame(230, 32, CN_NORMAL, 8'h01, "blink_off_f7");
        push_frame(262, 32, CN_NORMAL, 8'h00, "blink_on_f8");
        push_frame(294, 22, CN_NORMAL, 8'h00, "blink_on_f9");

        // Reset sampled while idx=5, div_cnt=2.
        wait_cyc(315);
        reset = 1'b0;
        for (int c = 316; c <= 318; c++) push(c, 8'hFF, 8'hFF, 1'b0, "midscan_reset");

        wait_cyc(318);
        reset = 1'b1;
        push_frame(319, 32, CN_NORMAL, 8'h00, "restart_f0");
        push_frame(351, 32, CN_NORMAL, 8'h00, "restart_f1");

        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
        #5;
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
